// File: rtl/dram_arb_pkg.sv
// Shared definitions for the two-port DRAM arbiter: FSM state encoding,
// port count and port indices.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    CALIB   = 2'd0,
    IDLE    = 2'd1,
    ISSUE   = 2'd2,
    WAIT_RD = 2'd3
  } state_t;

  localparam int   NUM_PORTS = 2;
  localparam logic PORT_IF   = 1'b0;  // instruction-fetch side
  localparam logic PORT_DM   = 1'b1;  // data-memory side

endpackage

// File: rtl/dram_arb_rr.sv
// Two-request picker. Default build: round-robin with a last-grant register
// that resets to the data port, so instruction fetch wins the first tie.
// With DRAM_ARB_FIXED_PRIO_EN defined the data port wins every tie and the
// last-grant register disappears.
module dram_arb_rr
  import dram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);

`ifdef DRAM_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, update};

  // data side takes any tie; grant is don't-care with no request
  always_comb grant = req[PORT_DM] ? PORT_DM : PORT_IF;
`else
  logic last;

  // on a tie serve the port that was not served last
  always_comb begin
    grant = req[PORT_DM] ? PORT_DM : PORT_IF;
    if (req[PORT_IF] && req[PORT_DM]) grant = ~last;
  end

  // remember who was granted, only when a grant is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last <= PORT_DM;
    else if (update) last <= grant;
  end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM user-interface controller between the instruction-fetch
// port (0) and the data-memory port (1). One command in flight at a time;
// read lines return to the port that issued them. Nothing is granted until
// calibration completes. Tie policy selectable with DRAM_ARB_FIXED_PRIO_EN.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      i_rst_n,
  input  logic                      i_p0_ren,
  input  logic                      i_p0_wen,
  input  logic [APP_ADDR_WIDTH-2:0] i_p0_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_p0_data,
  input  logic [APP_MASK_WIDTH-1:0] i_p0_mask,
  output logic                      o_p0_ack,
  output logic [APP_DATA_WIDTH-1:0] o_p0_rdata,
  output logic                      o_p0_rvalid,
  input  logic                      i_p1_ren,
  input  logic                      i_p1_wen,
  input  logic [APP_ADDR_WIDTH-2:0] i_p1_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_p1_data,
  input  logic [APP_MASK_WIDTH-1:0] i_p1_mask,
  output logic                      o_p1_ack,
  output logic [APP_DATA_WIDTH-1:0] o_p1_rdata,
  output logic                      o_p1_rvalid,
  output logic                      o_dram_ren,
  output logic                      o_dram_wen,
  output logic [APP_ADDR_WIDTH-2:0] o_dram_addr,
  output logic [APP_DATA_WIDTH-1:0] o_dram_data,
  output logic [APP_MASK_WIDTH-1:0] o_dram_mask,
  input  logic                      i_dram_busy,
  input  logic                      i_dram_calib_done,
  input  logic                      i_dram_rdata_valid,
  input  logic [APP_DATA_WIDTH-1:0] i_dram_rdata,
  output logic                      o_ready
);

  state_t     state;
  logic       owner;
  logic       op_wr;
  logic [1:0] req;
  logic       grant;
  logic       take;
  logic       fire;

  assign req  = {i_p1_ren | i_p1_wen, i_p0_ren | i_p0_wen};
  assign take = (state == IDLE) && (|req);
  // command is accepted on any ISSUE cycle the controller is not busy
  assign fire = (state == ISSUE) && !i_dram_busy;

  dram_arb_rr u_rr (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .req    (req),
    .update (take),
    .grant  (grant)
  );

  assign o_dram_ren = fire && !op_wr;
  assign o_dram_wen = fire && op_wr;
  assign o_p0_ack   = fire && (owner == PORT_IF);
  assign o_p1_ack   = fire && (owner == PORT_DM);
  assign o_ready    = (state == IDLE);

  // arbitration FSM: latch the winner's command, issue it, collect read data
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= CALIB;
      owner       <= PORT_IF;
      op_wr       <= 1'b0;
      o_dram_addr <= '0;
      o_dram_data <= '0;
      o_dram_mask <= '0;
      o_p0_rdata  <= '0;
      o_p1_rdata  <= '0;
      o_p0_rvalid <= 1'b0;
      o_p1_rvalid <= 1'b0;
    end else begin
      o_p0_rvalid <= 1'b0;
      o_p1_rvalid <= 1'b0;
      case (state)
        CALIB: if (i_dram_calib_done) state <= IDLE;
        IDLE: begin
          if (take) begin
            owner <= grant;
            // write wins when a port raises both strobes
            if (grant == PORT_DM) begin
              op_wr       <= i_p1_wen;
              o_dram_addr <= i_p1_addr;
              o_dram_data <= i_p1_data;
              o_dram_mask <= i_p1_mask;
            end else begin
              op_wr       <= i_p0_wen;
              o_dram_addr <= i_p0_addr;
              o_dram_data <= i_p0_data;
              o_dram_mask <= i_p0_mask;
            end
            state <= ISSUE;
          end
        end
        ISSUE: if (!i_dram_busy) state <= op_wr ? IDLE : WAIT_RD;
        WAIT_RD: begin
          if (i_dram_rdata_valid) begin
            if (owner == PORT_DM) begin
              o_p1_rdata  <= i_dram_rdata;
              o_p1_rvalid <= 1'b1;
            end else begin
              o_p0_rdata  <= i_dram_rdata;
              o_p0_rvalid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= CALIB;
      endcase
    end
  end

endmodule
